pc_ctrl: RTL and testbench
==========================

# pc_ctrl

Instruction-sequencing controller for the program counter. It runs the FETCH/DECODE/EXEC/UPDATE loop that decides, once per instruction, whether the PC increments, jumps or returns. It owns the DEPTH-entry return-address stack that supplies the PC's return-target input, and it handshakes with instruction memory. It sits between the decoder, the instruction memory port and the PC.

## Interface
Parameters:
- DEPTH, 8: return-address stack entries (power of two, ≥2)
- AW, 16: address width (matches PC)

Ports:
- CLK  in  1  system clock; all controller state updates on posedge
- RST  in  1  reset; asynchronous and active-high
- PC  in  AW  current PC value
- Imem_req  out  1  fetch request to instruction memory
- Imem_ack  in  1  instruction word available this cycle
- Instr_valid  out  1  one-cycle pulse: decoder must latch the instruction word
- Dec_jmp  in  1  decoded jump/branch
- Dec_cond  in  1  branch condition true
- Dec_call  in  1  decoded call
- Dec_ret  in  1  decoded return
- Dec_halt  in  1  decoded halt
- Stall  in  1  execute not finished; hold in EXEC
- PCpp  out  1  PC increment pulse
- jmp  out  1  PC load-immediate pulse (Imm is routed from the decoder to the PC directly)
- Ret  out  1  PC load-from-stack pulse
- DoST  out  AW  top-of-stack return address
- Ovf  out  1  sticky: call attempted with stack full
- Unf  out  1  sticky: return attempted with stack empty
- Halted  out  1  controller in HALT

## Operation
- States: FETCH, DECODE, EXEC, UPDATE, HALT. Reset enters FETCH.
- Reset values: Imem_req=0, Instr_valid=0, PCpp=jmp=Ret=0, Ovf=Unf=0, Halted=0, sp=0, DoST=0, all stack entries 0.
- FETCH
  - Imem_req=1 from the first cycle in FETCH and held until Imem_ack is sampled high on a posedge.
  - On that edge: Imem_req→0, Instr_valid=1 for the following cycle, next state DECODE.
- DECODE (one cycle)
  - Sample the Dec_* inputs and register one action.
  - Action priority: halt > ret > call > jmp.
  - A jump is taken only if Dec_jmp=1 and Dec_cond=1; if Dec_jmp=1 and Dec_cond=0, the action is sequential.
  - No flag set: sequential.
  - Next state EXEC.
- EXEC
  - Remain while Stall=1.
  - On the posedge with Stall=0, enter UPDATE and register the output pulse for the action: sequential→PCpp, jump→jmp, call→jmp, ret→Ret.
  - Halt action: go to HALT instead of UPDATE; no pulse.
- UPDATE
  - The registered pulse stays high for exactly this one cycle; the PC captures it on the negedge inside the cycle.
  - Next posedge: all pulses→0, state FETCH.
- HALT: all pulses 0, Imem_req=0, Halted=1. Exit only by RST.
- At most one of PCpp/jmp/Ret is high in any cycle.
- Return stack
  - sp counts valid entries, 0..DEPTH.
  - DoST = stack[sp-1] when sp>0, else 0. DoST is held stable throughout UPDATE.
- Call
  - Push (PC+1) mod 2^AW at the EXEC→UPDATE edge; 0xFFFF+1 wraps to 0x0000.
  - If sp=DEPTH: no push, sp unchanged, Ovf←1, jmp still issued.
- Ret
  - sp>0: Ret pulse in UPDATE; pop (sp−1) at the UPDATE→FETCH edge.
  - sp=0: Unf←1, PCpp issued instead of Ret, sp stays 0.
- Ovf and Unf are cleared only by RST.
- RST asserted in any state clears all registers immediately, including mid-handshake and during an UPDATE pulse. FETCH restarts after release.

## Timing
- Imem_req asserts one cycle after RST release and one cycle after each UPDATE.
- Minimum instruction period is 4 cycles: FETCH with same-cycle ack, then DECODE, EXEC with Stall=0, UPDATE.
- Each extra memory-wait cycle or Stall cycle adds exactly one cycle.
- Instr_valid rises the cycle after the ack edge.
- Decode inputs must be valid in the DECODE cycle.
- Outputs are registered; there is no combinational path from inputs to outputs.
- DoST is the only mux-derived output.
- All outputs settle within half a cycle of posedge, before the PC's negedge sample.

## Test plan
- Reset, then ack on the first FETCH cycle, sequential instruction, Stall=0 → PCpp high in the 4th cycle; PC 0→1; Imem_req reasserts the next cycle.
- Dec_jmp=1 with Dec_cond=1, then a separate instruction with Dec_jmp=1 and Dec_cond=0 → first issues jmp; second issues PCpp, never jmp.
- At PC=0x0010: call, then ret → stack holds 0x0011; DoST=0x0011 during the ret UPDATE; Ret pulses; sp returns to 0.
- DEPTH+1 consecutive calls → Ovf=1 after the last call; sp=DEPTH; jmp still pulsed. Then DEPTH+1 rets → DEPTH Ret pulses, then Unf=1 and PCpp on the last.
- Imem_ack delayed 3 cycles and Stall high for 2 cycles → instruction period is 9 cycles; Imem_req held steady throughout the wait; no pulses during the stall.
- RST pulsed during EXEC of a call, and Dec_halt in another run → RST gives sp=0, no pulse, FETCH restart; halt gives Halted=1 with no further Imem_req.

Source files
------------

// File: rtl/pc_ctrl.sv
// Instruction-sequencing controller: FETCH/DECODE/EXEC/UPDATE loop driving PC
// increment/jump/return pulses, with a DEPTH-entry return-address stack.
module pc_ctrl #(
   parameter int DEPTH = 8,
   parameter int AW    = 16
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic [AW-1:0] PC,
   output logic          Imem_req,
   input  logic          Imem_ack,
   output logic          Instr_valid,
   input  logic          Dec_jmp,
   input  logic          Dec_cond,
   input  logic          Dec_call,
   input  logic          Dec_ret,
   input  logic          Dec_halt,
   input  logic          Stall,
   output logic          PCpp,
   output logic          jmp,
   output logic          Ret,
   output logic [AW-1:0] DoST,
   output logic          Ovf,
   output logic          Unf,
   output logic          Halted
);

   localparam int SPW = $clog2(DEPTH) + 1;

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_UPDATE, S_HALT} state_e;
   typedef enum logic [2:0] {A_SEQ, A_JMP, A_CALL, A_RET, A_HALT} action_e;

   state_e           state_q, state_d;
   action_e          action_q, action_d;
   logic             imem_req_q, imem_req_d;
   logic             instr_valid_q, instr_valid_d;
   logic             pcpp_q, pcpp_d;
   logic             jmp_q, jmp_d;
   logic             ret_q, ret_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             halted_q, halted_d;
   logic [SPW-1:0]   sp_q, sp_d;
   logic [AW-1:0]    stack_q [DEPTH];
   logic [AW-1:0]    stack_d [DEPTH];
   logic [SPW-2:0]   top_idx;

   // NOTE: every variable gets a default at the top of always_comb, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d       = state_q;
      action_d      = action_q;
      imem_req_d    = imem_req_q;
      instr_valid_d = 1'b0;
      pcpp_d        = 1'b0;
      jmp_d         = 1'b0;
      ret_d         = 1'b0;
      ovf_d         = ovf_q;
      unf_d         = unf_q;
      halted_d      = halted_q;
      sp_d          = sp_q;
      stack_d       = stack_q;

      case (state_q)
         S_FETCH: begin
            // The ack only counts once the request is actually on the bus.
            if (!imem_req_q) begin
               imem_req_d = 1'b1;
            end else if (Imem_ack) begin
               imem_req_d    = 1'b0;
               instr_valid_d = 1'b1;
               state_d       = S_DECODE;
            end
         end
         S_DECODE: begin
            if (Dec_halt)                 action_d = A_HALT;
            else if (Dec_ret)             action_d = A_RET;
            else if (Dec_call)            action_d = A_CALL;
            else if (Dec_jmp && Dec_cond) action_d = A_JMP;
            else                          action_d = A_SEQ;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            if (!Stall) begin
               state_d = S_UPDATE;
               case (action_q)
                  A_JMP: jmp_d = 1'b1;
                  A_CALL: begin
                     jmp_d = 1'b1;
                     if (sp_q == SPW'(DEPTH)) begin
                        ovf_d = 1'b1;
                     end else begin
                        stack_d[sp_q[SPW-2:0]] = PC + AW'(1);
                        sp_d = sp_q + SPW'(1);
                     end
                  end
                  A_RET: begin
                     // Returning from an empty stack degrades to a sequential step.
                     if (sp_q == '0) begin
                        unf_d  = 1'b1;
                        pcpp_d = 1'b1;
                     end else begin
                        ret_d = 1'b1;
                     end
                  end
                  A_HALT: begin
                     state_d  = S_HALT;
                     halted_d = 1'b1;
                  end
                  default: pcpp_d = 1'b1;
               endcase
            end
         end
         S_UPDATE: begin
            state_d    = S_FETCH;
            imem_req_d = 1'b1;
            if (ret_q) sp_d = sp_q - SPW'(1);
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   // NOTE: the stack is a small register file that must read back as zero after
   // reset, so it is cleared with the rest of the state rather than left as RAM.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q       <= S_FETCH;
         action_q      <= A_SEQ;
         imem_req_q    <= 1'b0;
         instr_valid_q <= 1'b0;
         pcpp_q        <= 1'b0;
         jmp_q         <= 1'b0;
         ret_q         <= 1'b0;
         ovf_q         <= 1'b0;
         unf_q         <= 1'b0;
         halted_q      <= 1'b0;
         sp_q          <= '0;
         stack_q       <= '{default: '0};
      end else begin
         state_q       <= state_d;
         action_q      <= action_d;
         imem_req_q    <= imem_req_d;
         instr_valid_q <= instr_valid_d;
         pcpp_q        <= pcpp_d;
         jmp_q         <= jmp_d;
         ret_q         <= ret_d;
         ovf_q         <= ovf_d;
         unf_q         <= unf_d;
         halted_q      <= halted_d;
         sp_q          <= sp_d;
         stack_q       <= stack_d;
      end
   end

   // At sp == DEPTH the low bits wrap to 0, so subtracting one still lands on DEPTH-1.
   assign top_idx     = sp_q[SPW-2:0] - (SPW-1)'(1);
   assign DoST        = (sp_q != '0) ? stack_q[top_idx] : '0;
   assign Imem_req    = imem_req_q;
   assign Instr_valid = instr_valid_q;
   assign PCpp        = pcpp_q;
   assign jmp         = jmp_q;
   assign Ret         = ret_q;
   assign Ovf         = ovf_q;
   assign Unf         = unf_q;
   assign Halted      = halted_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: directed and random instructions checked against a
// per-instruction model of the PC, return stack and sticky flags.
module tb_pc_ctrl;

   localparam int DEPTH = 8;
   localparam int AW    = 16;

   logic          CLK = 1'b0;
   logic          RST;
   logic [AW-1:0] PC;
   logic          Imem_req, Imem_ack, Instr_valid;
   logic          Dec_jmp, Dec_cond, Dec_call, Dec_ret, Dec_halt, Stall;
   logic          PCpp, jmp, Ret, Ovf, Unf, Halted;
   logic [AW-1:0] DoST;

   int passed = 0;
   int total  = 0;

   // Reference model state
   logic [AW-1:0] m_stk [$];
   logic          m_ovf, m_unf;
   logic [AW-1:0] m_pc;

   pc_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
      .CLK(CLK), .RST(RST), .PC(PC),
      .Imem_req(Imem_req), .Imem_ack(Imem_ack), .Instr_valid(Instr_valid),
      .Dec_jmp(Dec_jmp), .Dec_cond(Dec_cond), .Dec_call(Dec_call),
      .Dec_ret(Dec_ret), .Dec_halt(Dec_halt), .Stall(Stall),
      .PCpp(PCpp), .jmp(jmp), .Ret(Ret), .DoST(DoST),
      .Ovf(Ovf), .Unf(Unf), .Halted(Halted)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (observed running, expected done)");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [AW-1:0] m_top();
      return (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : '0;
   endfunction

   // One instruction: fetch with ack_dly wait cycles, decode flags, stall cycles, update.
   task automatic run_instr(input int ack_dly, input int stall_cyc,
                            input bit j, input bit c, input bit cl, input bit r, input bit h,
                            input logic [AW-1:0] imm, input bit abort);
      int w;
      logic e_pcpp, e_jmp, e_ret;
      logic [AW-1:0] e_dost;
      w = 0;
      while (Imem_req !== 1'b1 && w < 8) begin
         @(negedge CLK);
         w++;
      end
      check("req_up", Imem_req, 1);
      for (int i = 0; i < ack_dly; i++) begin
         Imem_ack = 1'b0;
         check("req_held", Imem_req, 1);
         check("wait_quiet", {Instr_valid, PCpp, jmp, Ret}, 0);
         @(negedge CLK);
      end
      Imem_ack = 1'b1;
      @(negedge CLK);
      Imem_ack = 1'b0;
      check("ivalid_decode", Instr_valid, 1);
      check("req_drop", Imem_req, 0);
      {Dec_jmp, Dec_cond, Dec_call, Dec_ret, Dec_halt} = {j, c, cl, r, h};
      @(negedge CLK);
      {Dec_jmp, Dec_cond, Dec_call, Dec_ret, Dec_halt} = '0;
      check("ivalid_exec", Instr_valid, 0);
      if (abort) begin
         RST = 1'b1;
         #1;
         check("rst_quiet", {Imem_req, Instr_valid, PCpp, jmp, Ret, Ovf, Unf, Halted}, 0);
         check("rst_dost", DoST, 0);
         @(negedge CLK);
         RST = 1'b0;
         m_stk.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
         check("rst_release", {Imem_req, PCpp, jmp, Ret}, 0);
         return;
      end
      for (int i = 0; i < stall_cyc; i++) begin
         Stall = 1'b1;
         check("stall_quiet", {PCpp, jmp, Ret}, 0);
         @(negedge CLK);
      end
      Stall = 1'b0;
      check("exec_quiet", {PCpp, jmp, Ret, Imem_req}, 0);
      @(negedge CLK);

      e_pcpp = 1'b0; e_jmp = 1'b0; e_ret = 1'b0;
      if (h) begin
      end else if (r) begin
         if (m_stk.size() > 0) e_ret = 1'b1;
         else begin m_unf = 1'b1; e_pcpp = 1'b1; end
      end else if (cl) begin
         e_jmp = 1'b1;
         if (m_stk.size() < DEPTH) m_stk.push_back(m_pc + 16'd1);
         else m_ovf = 1'b1;
      end else if (j && c) e_jmp = 1'b1;
      else e_pcpp = 1'b1;
      e_dost = m_top();

      check("pulses", {PCpp, jmp, Ret}, {e_pcpp, e_jmp, e_ret});
      check("dost_update", DoST, e_dost);
      check("ovf", Ovf, m_ovf);
      check("unf", Unf, m_unf);
      check("halted", Halted, h);
      check("req_update", Imem_req, 0);

      if (e_ret) m_pc = m_stk.pop_back();
      else if (e_jmp) m_pc = imm;
      else if (e_pcpp) m_pc = m_pc + 16'd1;

      @(negedge CLK);
      PC = m_pc;
      if (h) begin
         for (int i = 0; i < 4; i++) begin
            Imem_ack = 1'b1;
            check("halt_noreq", {Imem_req, PCpp, jmp, Ret}, 0);
            check("halt_flag", Halted, 1);
            @(negedge CLK);
         end
         Imem_ack = 1'b0;
      end else begin
         check("refetch_req", Imem_req, 1);
         check("refetch_quiet", {PCpp, jmp, Ret}, 0);
         check("dost_fetch", DoST, m_top());
      end
   endtask

   initial begin
      RST = 1'b1;
      m_pc = '0;
      PC = '0;
      Imem_ack = 1'b0;
      {Dec_jmp, Dec_cond, Dec_call, Dec_ret, Dec_halt} = '0;
      Stall = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      repeat (2) @(negedge CLK);
      check("reset_outs", {Imem_req, Instr_valid, PCpp, jmp, Ret, Ovf, Unf, Halted}, 0);
      check("reset_dost", DoST, 0);
      RST = 1'b0;
      @(negedge CLK);
      check("req_after_release", Imem_req, 1);

      // Sequential, then taken and untaken jumps
      run_instr(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0);
      check("pc_after_seq", m_pc, 16'h0001);
      run_instr(0, 0, 1, 1, 0, 0, 0, 16'h0040, 0);
      run_instr(0, 0, 1, 0, 0, 0, 0, 16'h0999, 0);
      run_instr(1, 0, 1, 1, 0, 0, 0, 16'h0010, 0);

      // Call at 0x0010 then return
      run_instr(0, 0, 0, 0, 1, 0, 0, 16'h0200, 0);
      run_instr(0, 0, 0, 0, 0, 1, 0, 16'h0000, 0);
      check("pc_after_ret", m_pc, 16'h0011);

      // Overflow then underflow
      for (int i = 0; i <= DEPTH; i++)
         run_instr(0, 0, 0, 0, 1, 0, 0, 16'($urandom), 0);
      for (int i = 0; i <= DEPTH; i++)
         run_instr(0, 0, 0, 0, 0, 1, 0, 16'h0000, 0);

      // Slow memory and stalled execute: 9-cycle instruction
      run_instr(3, 2, 0, 0, 0, 0, 0, 16'h0000, 0);

      // Return address wraps at the top of the address space
      run_instr(0, 0, 1, 1, 0, 0, 0, 16'hFFFF, 0);
      run_instr(0, 1, 0, 0, 1, 0, 0, 16'h1234, 0);
      run_instr(0, 0, 0, 0, 0, 1, 0, 16'h0000, 0);
      check("pc_after_wrap_ret", m_pc, 16'h0000);

      // Random mix (halt excluded)
      for (int n = 0; n < 60; n++)
         run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                   1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 3) == 0), 1'b0, 16'($urandom), 0);

      // Reset in the middle of a call's EXEC, then a return from the cleared stack
      run_instr(0, 0, 0, 0, 1, 0, 0, 16'h0300, 0);
      run_instr(0, 0, 0, 0, 1, 0, 0, 16'h0400, 1);
      run_instr(0, 0, 0, 0, 0, 1, 0, 16'h0000, 0);

      // Halt
      run_instr(1, 1, 0, 0, 0, 0, 1, 16'h0000, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
